conv_scratchpad_mem: RTL and testbench

- Word-organised scratchpad that responds to the convolution controller's memory requests.
- Serves filter and window reads as 32-bit words with 1-cycle latency.
- Accepts byte-lane output writes selected by `memory_offset`.
- When the controller raises `writeOut`, streams the output region to the testbench/host over a valid/ready dump port.
- Sits between the controller/datapath and the external loader/checker.

---
 rtl/conv_scratchpad_mem.sv | 115 +++++++++++
 tb/tb_conv_scratchpad_mem.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/conv_scratchpad_mem.sv
// Word-organised scratchpad for the convolution controller: 1-cycle reads, byte-lane writes,
// full-word preload, and a valid/ready dump of the output region on writeOut.
module conv_scratchpad_mem #(
    parameter int unsigned DEPTH     = 256,
    parameter int unsigned OUT_BASE  = 64,
    parameter int unsigned OUT_WORDS = 43
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  address,
    input  logic        read_en,
    input  logic        write,
    input  logic [1:0]  memory_offset,
    input  logic [7:0]  wdata,
    input  logic        writeOut,
    input  logic        load_en,
    input  logic [7:0]  load_addr,
    input  logic [31:0] load_data,
    output logic [31:0] rdata,
    output logic        rvalid,
    output logic        dump_valid,
    input  logic        dump_ready,
    output logic [7:0]  dump_addr,
    output logic [31:0] dump_data,
    output logic        dump_done
);

    localparam logic [7:0] BaseAddr = 8'(OUT_BASE);
    localparam logic [7:0] LastAddr = 8'(OUT_BASE + OUT_WORDS - 1);

    if (OUT_BASE + OUT_WORDS > DEPTH || DEPTH > 256) begin : g_param_check
        $error("conv_scratchpad_mem: output region exceeds the array");
    end

    typedef enum logic [1:0] {StIdle, StDump, StDone} state_e;

    state_e      state_q, state_d;
    logic [7:0]  ptr_q, ptr_d;
    logic [31:0] rdata_q;
    logic        rvalid_q;
    logic [31:0] mem_q [DEPTH];

    logic idle_req;
    logic addr_ok;
    logic load_ok;
    logic load_we;
    logic byte_we;

    // Requests are only honoured in IDLE and never during the reset cycle.
    assign idle_req = (state_q == StIdle) && !reset;
    assign addr_ok  = (32'(address) < DEPTH);
    assign load_ok  = (32'(load_addr) < DEPTH);
    assign load_we  = idle_req && load_en && load_ok;
    assign byte_we  = idle_req && write && addr_ok && !(load_we && (load_addr == address));

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            StIdle: begin
                if (writeOut) begin
                    state_d = StDump;
                end
            end
            StDump: begin
                if (dump_ready) begin
                    ptr_d = ptr_q + 8'd1;
                    if (ptr_q == LastAddr) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StDone;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= StIdle;
            ptr_q    <= BaseAddr;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            rvalid_q <= idle_req && read_en;
            if (idle_req && read_en) begin
                rdata_q <= addr_ok ? mem_q[address] : '0;
            end
        end
    end

    // Array is deliberately left out of reset so preloaded contents survive it.
    always_ff @(posedge clock) begin
        if (load_we) begin
            mem_q[load_addr] <= load_data;
        end
        if (byte_we) begin
            mem_q[address][{memory_offset, 3'b000} +: 8] <= wdata;
        end
    end

    assign rdata      = rdata_q;
    assign rvalid     = rvalid_q;
    assign dump_valid = (state_q == StDump);
    assign dump_addr  = ptr_q;
    assign dump_data  = (state_q == StDump) ? mem_q[ptr_q] : '0;
    assign dump_done  = (state_q == StDone);

endmodule

// File: tb/tb_conv_scratchpad_mem.sv
// Directed bench for conv_scratchpad_mem: read scoreboard, byte writes, and dump sequences.
module tb_conv_scratchpad_mem;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  address;
    logic        read_en;
    logic        write;
    logic [1:0]  memory_offset;
    logic [7:0]  wdata;
    logic        writeOut;
    logic        load_en;
    logic [7:0]  load_addr;
    logic [31:0] load_data;
    logic [31:0] rdata;
    logic        rvalid;
    logic        dump_valid;
    logic        dump_ready;
    logic [7:0]  dump_addr;
    logic [31:0] dump_data;
    logic        dump_done;

    int checks = 0;
    int errors = 0;
    logic exp_rv = 1'b0;
    logic [31:0] sb [$];

    conv_scratchpad_mem #(
        .DEPTH    (256),
        .OUT_BASE (64),
        .OUT_WORDS(43)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .address      (address),
        .read_en      (read_en),
        .write        (write),
        .memory_offset(memory_offset),
        .wdata        (wdata),
        .writeOut     (writeOut),
        .load_en      (load_en),
        .load_addr    (load_addr),
        .load_data    (load_data),
        .rdata        (rdata),
        .rvalid       (rvalid),
        .dump_valid   (dump_valid),
        .dump_ready   (dump_ready),
        .dump_addr    (dump_addr),
        .dump_data    (dump_data),
        .dump_done    (dump_done)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] pat_word(input int a);
        return 32'hC0DE_0000 | 32'(a);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock; afterwards compare rvalid and pop the read scoreboard.
    task automatic step();
        @(posedge clock);
        #1;
        chk("rvalid", 32'(rvalid), 32'(exp_rv));
        if (rvalid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL rdata_unexpected observed=%h expected=none", rdata);
            end else begin
                chk("rdata", rdata, sb.pop_front());
            end
        end else if (exp_rv && sb.size() > 0) begin
            void'(sb.pop_front());
        end
        exp_rv = 1'b0;
    endtask

    task automatic load(input logic [7:0] a, input logic [31:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        step();
        load_en = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, input logic [31:0] exp);
        read_en = 1'b1; address = a;
        sb.push_back(exp);
        exp_rv = 1'b1;
        step();
        read_en = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [1:0] lane, input logic [7:0] d);
        write = 1'b1; address = a; memory_offset = lane; wdata = d;
        step();
        write = 1'b0;
    endtask

    // Drive the dump handshake until stop_after beats are accepted or the budget runs out.
    task automatic run_dump(input bit toggle, input int stop_after);
        int beats = 0;
        int exp_a = 64;
        bit rpat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (beats >= stop_after) break;
            chk("dump_valid", 32'(dump_valid), 32'd1);
            chk("dump_addr", 32'(dump_addr), 32'(exp_a));
            chk("dump_data", dump_data, pat_word(exp_a));
            dump_ready = toggle ? rpat[cyc % 4] : 1'b1;
            read_en = (cyc == 3); address = 8'd80;
            write = (cyc == 5); memory_offset = 2'd0; wdata = 8'hEE;
            load_en = (cyc == 7); load_addr = 8'd90; load_data = 32'h0;
            if (dump_ready) begin
                beats++;
                exp_a++;
            end
            step();
        end
        read_en = 1'b0; write = 1'b0; load_en = 1'b0;
        chk("dump_beats", 32'(beats), 32'(stop_after));
        if (stop_after == 43) begin
            chk("dump_valid_end", 32'(dump_valid), 32'd0);
            chk("dump_done_end", 32'(dump_done), 32'd1);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; address = '0; read_en = 1'b0; write = 1'b0; memory_offset = '0;
        wdata = '0; writeOut = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
        dump_ready = 1'b0;
        step();
        step();
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_dump_valid", 32'(dump_valid), 32'd0);
        chk("rst_dump_addr", 32'(dump_addr), 32'd64);
        chk("rst_dump_data", dump_data, 32'h0);
        chk("rst_dump_done", 32'(dump_done), 32'd0);
        reset = 1'b0;
        step();

        // Single read, then three back-to-back reads.
        load(8'd5, 32'h4433_2211);
        load(8'd6, 32'h6666_0006);
        load(8'd7, 32'h7777_0007);
        rd(8'd5, 32'h4433_2211);
        step();
        rd(8'd5, 32'h4433_2211);
        rd(8'd6, 32'h6666_0006);
        rd(8'd7, 32'h7777_0007);
        step();

        // Byte-lane writes.
        load(8'd70, 32'hAABB_CCDD);
        wr(8'd70, 2'd2, 8'h5A);
        rd(8'd70, 32'hAA5A_CCDD);
        wr(8'd70, 2'd0, 8'h00);
        rd(8'd70, 32'hAA5A_CC00);

        // Read-before-write on the same word.
        read_en = 1'b1; write = 1'b1; address = 8'd70; memory_offset = 2'd3; wdata = 8'hFF;
        sb.push_back(32'hAA5A_CC00);
        exp_rv = 1'b1;
        step();
        read_en = 1'b0; write = 1'b0;
        rd(8'd70, 32'hFF5A_CC00);

        // Load wins over a same-word write; different words both land.
        load_en = 1'b1; load_addr = 8'd70; load_data = 32'h0;
        write = 1'b1; address = 8'd70; memory_offset = 2'd1; wdata = 8'h77;
        step();
        load_en = 1'b0; write = 1'b0;
        rd(8'd70, 32'h0000_0000);
        load_en = 1'b1; load_addr = 8'd71; load_data = 32'h1234_5678;
        write = 1'b1; address = 8'd70; memory_offset = 2'd0; wdata = 8'h99;
        step();
        load_en = 1'b0; write = 1'b0;
        rd(8'd70, 32'h0000_0099);
        rd(8'd71, 32'h1234_5678);

        for (int i = 64; i <= 106; i++) load(8'(i), pat_word(i));

        // Dump with ready high; a read in the writeOut cycle still completes.
        dump_ready = 1'b1;
        writeOut = 1'b1; read_en = 1'b1; address = 8'd5;
        sb.push_back(32'h4433_2211);
        exp_rv = 1'b1;
        step();
        writeOut = 1'b0; read_en = 1'b0;
        run_dump(1'b0, 43);
        read_en = 1'b1; address = 8'd5;
        step();
        read_en = 1'b0;
        chk("done_sticky", 32'(dump_done), 32'd1);

        // Dump with ready toggling.
        do_reset();
        writeOut = 1'b1;
        step();
        writeOut = 1'b0;
        run_dump(1'b1, 43);

        // Reset after 10 beats, then restart from the base.
        do_reset();
        writeOut = 1'b1;
        step();
        writeOut = 1'b0;
        run_dump(1'b0, 10);
        do_reset();
        chk("mid_rst_valid", 32'(dump_valid), 32'd0);
        chk("mid_rst_done", 32'(dump_done), 32'd0);
        chk("mid_rst_addr", 32'(dump_addr), 32'd64);
        rd(8'd64, pat_word(64));
        rd(8'd74, pat_word(74));
        writeOut = 1'b1;
        step();
        writeOut = 1'b0;
        run_dump(1'b0, 43);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
